id_stage_pipe: RTL

- Parametrised decode stage for the 5-stage pipeline: decodes one 32-bit instruction per cycle, reads an internal register file, sign-extends the immediate and selects operand 2.
- Registers all results into an ID/EX pipeline register with a valid/ready handshake.
- Adds features the previous decode stage lacked: stall, flush, write-back bypass, load-use hazard bubble, illegal-opcode flag and configurable data width/register count.

---
 rtl/id_stage_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// Instruction decode stage: field decode, register file read with write-back
// bypass, operand-2 select and an ID/EX register with valid/ready, flush and load-use bubble.
module id_stage_pipe #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_dest,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_reg1,
  output logic [XLEN-1:0] out_reg2,
  output logic [XLEN-1:0] out_op2,
  output logic [4:0]      out_dest,
  output logic            out_wb_en,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [1:0]      out_branch_type,
  output logic [3:0]      out_exe_cmd,
  output logic            out_illegal,
  output logic            hazard_stall
);

  typedef enum logic [5:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd3,
    OP_AND  = 6'd5,
    OP_OR   = 6'd6,
    OP_ADDI = 6'd32,
    OP_LD   = 6'd36,
    OP_ST   = 6'd37,
    OP_BEZ  = 6'd40,
    OP_BNE  = 6'd41,
    OP_JMP  = 6'd42
  } opcode_e;

  logic [5:0]      op;
  logic [4:0]      src1, src2, rd;
  logic [XLEN-1:0] imm_ext;

  assign op      = in_instr[31:26];
  assign src1    = in_instr[25:21];
  assign src2    = in_instr[20:16];
  assign rd      = in_instr[15:11];
  assign imm_ext = XLEN'(signed'(in_instr[15:0]));

  logic [3:0] d_cmd;
  logic [1:0] d_br;
  logic       d_wb, d_mr, d_mw, d_imm, d_rtype, d_ill, d_use1, d_use2;

  always_comb begin
    d_cmd   = '0;
    d_br    = 2'b00;
    d_wb    = 1'b0;
    d_mr    = 1'b0;
    d_mw    = 1'b0;
    d_imm   = 1'b0;
    d_rtype = 1'b0;
    d_ill   = 1'b0;
    d_use1  = 1'b1;
    unique case (op)
      OP_ADD:  begin d_cmd = 4'd1; d_wb = 1'b1; d_rtype = 1'b1; end
      OP_SUB:  begin d_cmd = 4'd2; d_wb = 1'b1; d_rtype = 1'b1; end
      OP_AND:  begin d_cmd = 4'd3; d_wb = 1'b1; d_rtype = 1'b1; end
      OP_OR:   begin d_cmd = 4'd4; d_wb = 1'b1; d_rtype = 1'b1; end
      OP_ADDI: begin d_cmd = 4'd1; d_wb = 1'b1; d_imm = 1'b1; end
      OP_LD:   begin d_cmd = 4'd1; d_wb = 1'b1; d_mr = 1'b1; d_imm = 1'b1; end
      OP_ST:   begin d_cmd = 4'd1; d_mw = 1'b1; d_imm = 1'b1; end
      OP_BEZ:  begin d_br = 2'b01; d_imm = 1'b1; end
      OP_BNE:  begin d_br = 2'b10; d_imm = 1'b1; end
      OP_JMP:  begin d_br = 2'b11; d_imm = 1'b1; d_use1 = 1'b0; end
      OP_NOP:  d_use1 = 1'b0;
      default: begin d_ill = 1'b1; d_use1 = 1'b0; end
    endcase
    d_use2 = d_rtype | (op == OP_ST) | (op == OP_BNE);
  end

  // Register file is sized to the full 5-bit index space; entries at or above
  // NREGS are never written, so they stay at their reset value and trim away.
  logic [XLEN-1:0] rf [32];
  logic            wb_legal;

  assign wb_legal = wb_en && (int'(wb_dest) < NREGS) && !(ZERO_REG != 0 && wb_dest == 5'd0);

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 32; i++) begin
      if (!rst)                              rf[i] <= '0;
      else if (wb_legal && wb_dest == 5'(i)) rf[i] <= wb_data;
    end
  end

  logic            rd1_ok, rd2_ok;
  logic [XLEN-1:0] reg1_val, reg2_val;

  assign rd1_ok   = (int'(src1) < NREGS) && !(ZERO_REG != 0 && src1 == 5'd0);
  assign rd2_ok   = (int'(src2) < NREGS) && !(ZERO_REG != 0 && src2 == 5'd0);
  assign reg1_val = !rd1_ok ? '0 : (wb_legal && wb_dest == src1) ? wb_data : rf[src1];
  assign reg2_val = !rd2_ok ? '0 : (wb_legal && wb_dest == src2) ? wb_data : rf[src2];

  logic adv, haz;

  assign adv = !out_valid || out_ready;
  assign haz = in_valid && out_valid && out_mem_read && (out_dest != 5'd0) &&
               ((d_use1 && out_dest == src1) || (d_use2 && out_dest == src2));
  assign hazard_stall = haz;
  assign in_ready     = flush || (adv && !haz);

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_reg1        <= '0;
      out_reg2        <= '0;
      out_op2         <= '0;
      out_dest        <= '0;
      out_wb_en       <= 1'b0;
      out_mem_read    <= 1'b0;
      out_mem_write   <= 1'b0;
      out_branch_type <= 2'b00;
      out_exe_cmd     <= '0;
      out_illegal     <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      if (haz || !in_valid) begin
        out_valid <= 1'b0;
      end else begin
        out_valid       <= 1'b1;
        out_pc          <= in_pc;
        out_reg1        <= reg1_val;
        out_reg2        <= reg2_val;
        out_op2         <= d_imm ? imm_ext : reg2_val;
        out_dest        <= d_rtype ? rd : src2;
        out_wb_en       <= d_wb;
        out_mem_read    <= d_mr;
        out_mem_write   <= d_mw;
        out_branch_type <= d_br;
        out_exe_cmd     <= d_cmd;
        out_illegal     <= d_ill;
      end
    end
  end

endmodule
